// File: rtl/snake_pixel_renderer_pkg.sv
// Shared constants for the snake pixel renderer: raster geometry, board size,
// palette and the row-scanner state encoding.
package snake_pixel_renderer_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_TOTAL    = 800;
    localparam int V_ACTIVE   = 480;
    localparam int V_TOTAL    = 525;
    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int CELL_SHIFT = 3;
    localparam int CELL_BITS  = 7;

    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_BORDER = 12'h888;
    localparam logic [11:0] COL_HEAD   = 12'h0F0;
    localparam logic [11:0] COL_BODY   = 12'h0A0;
    localparam logic [11:0] COL_FRUIT  = 12'hF00;
    localparam logic [11:0] COL_DEAD   = 12'hF80;

    typedef enum logic [2:0] {
        SCAN_IDLE,
        SCAN_CLEAR,
        SCAN_RUN,
        SCAN_DRAIN,
        SCAN_HOLD
    } scan_state_t;

    function automatic logic is_border(input logic [CELL_BITS-1:0] col,
                                       input logic [CELL_BITS-1:0] row);
        return (col == '0) || (col == CELL_BITS'(GRID_W - 1)) ||
               (row == '0) || (row == CELL_BITS'(GRID_H - 1));
    endfunction

endpackage

// File: rtl/snake_pixel_renderer_row_scanner.sv
// Builds a one-row body occupancy bitmap during horizontal blanking by walking
// the snake segment list, then publishes it at end of line.
//
// state      | meaning
// SCAN_IDLE  | waiting for the scan trigger at X==H_ACTIVE
// SCAN_CLEAR | clear shadow row, reset index, sample snake_length
// SCAN_RUN   | issue segment reads, capture the previous read's result
// SCAN_DRAIN | capture the final segment returned by the read port
// SCAN_HOLD  | wait for end of line, then copy shadow -> active
module snake_row_scanner
    import snake_pixel_renderer_pkg::*;
#(
    parameter int SNAKE_LENGTH_BIT  = 4,
    parameter int PIXEL_DISPLAY_BIT = 9
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic [PIXEL_DISPLAY_BIT:0]   x,
    input  logic [PIXEL_DISPLAY_BIT:0]   y,
    input  logic [SNAKE_LENGTH_BIT-1:0]  snake_length,
    input  logic [CELL_BITS-1:0]         body_rd_x,
    input  logic [CELL_BITS-1:0]         body_rd_y,
    output logic [SNAKE_LENGTH_BIT-1:0]  body_rd_idx,
    output logic [GRID_W-1:0]            active_row,
    output logic                         scan_busy
);

    localparam int PW = PIXEL_DISPLAY_BIT + 1;

    scan_state_t                 state, state_nxt;
    logic [SNAKE_LENGTH_BIT-1:0] idx;
    logic [SNAKE_LENGTH_BIT-1:0] len_q;
    logic [CELL_BITS-1:0]        row_q;
    logic [CELL_BITS-1:0]        target_row;
    logic [GRID_W-1:0]           shadow;
    logic [PW-1:0]               y_next;
    logic                        trigger;
    logic                        last_issue;
    logic                        line_end;
    logic                        capture;
    logic                        hit;

    // Last line of a cell row (or last line of the frame) prepares the next row.
    assign trigger    = (x == PW'(H_ACTIVE)) &&
                        ((y[CELL_SHIFT-1:0] == '1) || (y == PW'(V_TOTAL - 1)));
    assign y_next     = y + PW'(1);
    assign target_row = (y == PW'(V_TOTAL - 1)) ? '0 : CELL_BITS'(y_next >> CELL_SHIFT);
    assign last_issue = (idx == len_q - SNAKE_LENGTH_BIT'(1));
    assign line_end   = (x == PW'(H_TOTAL - 1));

    // Read data lags the issued index by one cycle, so the first RUN cycle has nothing to capture.
    assign capture = ((state == SCAN_RUN) && (idx != '0)) || (state == SCAN_DRAIN);
    assign hit     = capture && (body_rd_y == row_q) && (body_rd_x < CELL_BITS'(GRID_W));

    assign body_rd_idx = idx;
    assign scan_busy   = (state != SCAN_IDLE);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state <= SCAN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SCAN_IDLE:  if (trigger) state_nxt = SCAN_CLEAR;
            SCAN_CLEAR: state_nxt = (snake_length != '0) ? SCAN_RUN : SCAN_HOLD;
            SCAN_RUN:   if (last_issue) state_nxt = SCAN_DRAIN;
            SCAN_DRAIN: state_nxt = SCAN_HOLD;
            SCAN_HOLD:  if (line_end) state_nxt = SCAN_IDLE;
            default:    state_nxt = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            len_q      <= '0;
            row_q      <= '0;
            shadow     <= '0;
            active_row <= '0;
        end else begin
            if ((state == SCAN_IDLE) && trigger) begin
                row_q <= target_row;
            end
            if (state == SCAN_CLEAR) begin
                shadow <= '0;
                idx    <= '0;
                len_q  <= snake_length;
            end
            if ((state == SCAN_RUN) && !last_issue) begin
                idx <= idx + SNAKE_LENGTH_BIT'(1);
            end
            if (hit) begin
                shadow[body_rd_x] <= 1'b1;
            end
            if ((state == SCAN_HOLD) && line_end) begin
                active_row <= shadow;
                idx        <= '0;
            end
        end
    end

endmodule

// File: rtl/snake_pixel_renderer.sv
// Snake game pixel renderer: priority colour mux over border, head, fruit and
// the scanned body row, with RGB and syncs registered together.
module snake_pixel_renderer
    import snake_pixel_renderer_pkg::*;
#(
    parameter int SNAKE_LENGTH_BIT  = 4,
    parameter int PIXEL_DISPLAY_BIT = 9
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic [PIXEL_DISPLAY_BIT:0]   X,
    input  logic [PIXEL_DISPLAY_BIT:0]   Y,
    input  logic                         display_area,
    input  logic                         h_sync_in,
    input  logic                         v_sync_in,
    input  logic [CELL_BITS-1:0]         snake_head_x,
    input  logic [CELL_BITS-1:0]         snake_head_y,
    input  logic [CELL_BITS-1:0]         fruit_x,
    input  logic [CELL_BITS-1:0]         fruit_y,
    input  logic [SNAKE_LENGTH_BIT-1:0]  snake_length,
    input  logic                         game_over,
    output logic [SNAKE_LENGTH_BIT-1:0]  body_rd_idx,
    input  logic [CELL_BITS-1:0]         body_rd_x,
    input  logic [CELL_BITS-1:0]         body_rd_y,
    output logic [3:0]                   VGA_R,
    output logic [3:0]                   VGA_G,
    output logic [3:0]                   VGA_B,
    output logic                         VGA_HS,
    output logic                         VGA_VS,
    output logic                         scan_busy
);

    logic [GRID_W-1:0]    active_row;
    logic [CELL_BITS-1:0] col;
    logic [CELL_BITS-1:0] row;
    logic                 body_hit;
    logic [11:0]          pixel;

    snake_row_scanner #(
        .SNAKE_LENGTH_BIT  (SNAKE_LENGTH_BIT),
        .PIXEL_DISPLAY_BIT (PIXEL_DISPLAY_BIT)
    ) u_scanner (
        .clock_25     (clock_25),
        .reset        (reset),
        .x            (X),
        .y            (Y),
        .snake_length (snake_length),
        .body_rd_x    (body_rd_x),
        .body_rd_y    (body_rd_y),
        .body_rd_idx  (body_rd_idx),
        .active_row   (active_row),
        .scan_busy    (scan_busy)
    );

    assign col      = CELL_BITS'(X >> CELL_SHIFT);
    assign row      = CELL_BITS'(Y >> CELL_SHIFT);
    assign body_hit = (col < CELL_BITS'(GRID_W)) ? active_row[col] : 1'b0;

    always_comb begin
        pixel = COL_BG;
        if (!display_area) begin
            pixel = 12'h000;
        end else if (is_border(col, row)) begin
            pixel = COL_BORDER;
        end else if ((col == snake_head_x) && (row == snake_head_y)) begin
            pixel = game_over ? COL_DEAD : COL_HEAD;
        end else if ((col == fruit_x) && (row == fruit_y)) begin
            pixel = COL_FRUIT;
        end else if (body_hit) begin
            pixel = game_over ? COL_DEAD : COL_BODY;
        end
    end

    // Syncs ride the same register stage as RGB so they stay aligned at the connector.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= pixel;
            VGA_HS <= h_sync_in;
            VGA_VS <= v_sync_in;
        end
    end

endmodule
